toggle_leds_cfg_seq: RTL and testbench
======================================

# toggle_leds_cfg_seq

AXI4-Lite master sequencer that configures and drives the toggle_leds peripheral from programmable logic, with no processor involved. On `start` it writes the four slave registers, reads each back and checks it, then optionally enters a run loop. In that loop it rotates an LED pattern into register 0 once every `C_TICK_CYCLES` clocks. It sits between board-level control (button/switch or a top-level FSM) and the toggle_leds S00_AXI port.

## Interface
- C_M_AXI_ADDR_WIDTH, 4, AXI address width (registers at 0x0, 0x4, 0x8, 0xC)
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
- C_LED_WIDTH, 4, width of the rotating LED pattern
- C_TICK_CYCLES, 100000000, clocks between run-mode writes (≥2)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins init sequence; ignored while busy=1
- run_en  in  1  level; enables the run loop after a successful init
- busy  out  1  high from the cycle after start until DONE/ERR/IDLE is reached
- done  out  1  sticky high after init passes; cleared by start
- error  out  1  sticky high on readback mismatch or non-OKAY response; cleared by start
- led_pattern  out  C_LED_WIDTH  last value written to reg0 in run mode
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1; M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RUN_WAIT, RUN_WR, RUN_RESP, DONE, ERR.
- IDLE + start: clear done and error; set idx=0; go to WR_ADDR_DATA.
- Init write idx (0..3): address = idx*4, data = idx+1, WSTRB=0xF, PROT=0. After write 3 completes, idx=0 and go to RD_ADDR.
- Init read idx: address = idx*4. Compare RDATA with idx+1; a mismatch or RRESP≠OKAY sets error → ERR. After read 3 passes, set done, then go to RUN_WAIT if run_en, else DONE.
- BRESP≠OKAY on any write: set error → ERR.
- RUN_WAIT: the tick counter counts 0..C_TICK_CYCLES-1. On terminal count, rotate led_pattern left by 1 (MSB wraps to LSB), write {0, new pattern} to 0x0 (RUN_WR/RUN_RESP), then return to RUN_WAIT with the counter at 0.
- RUN_WAIT and run_en=0: go to DONE. DONE and run_en=1: go to RUN_WAIT with the counter at 0. A write already issued always completes first.
- DONE/ERR + start: restart init as from IDLE. start is ignored while busy.

## Timing
- Reset values: all VALID/READY outputs 0, AWADDR/ARADDR/WDATA 0, WSTRB 0, busy 0, done 0, error 0, led_pattern = 1, state IDLE, counter 0.
- Writes: AWVALID and WVALID assert together in the cycle after entering WR_ADDR_DATA/RUN_WR. Each drops independently in the cycle after its own handshake (VALID&READY). Address and data are held stable while VALID is high.
- BREADY asserts once both AW and W have been accepted. It is held until BVALID, then dropped the next cycle.
- Reads: ARVALID is held until ARREADY. RREADY asserts after AR is accepted; RDATA is sampled on the RVALID&RREADY cycle.
- Only one transaction is outstanding at a time; no read overlaps a write.
- A slave with READY tied high and one-cycle responses gives 3 cycles per write and 3 per read. Full init takes 24 cycles from start to done.
- The run-loop write period is exactly C_TICK_CYCLES plus the write latency. led_pattern updates in the cycle the write's B handshake completes.
- busy: low in IDLE/DONE/ERR, high elsewhere. It stays high in RUN_* states.
- ARESETN asserted mid-transaction: all outputs return to reset values asynchronously. The slave is assumed reset by the same ARESETN.

## Test plan
- Reset then start, with a toggle_leds slave: writes 1,2,3,4 to 0x0..0xC; reads back 1,2,3,4; done=1, error=0, busy=0 at cycle 24 with zero-wait slave.
- Slave model returns RDATA=0xDEAD at 0x8: error=1, done=0, state ERR, no further AXI traffic. A subsequent start clears error and reruns init.
- Slave model returns BRESP=SLVERR on the 0x4 write: error=1, sequence stops, no reads issued.
- run_en=1, C_TICK_CYCLES=8: reg0 receives 0x2, 0x4, 0x8, 0x1, 0x2 at 8+3-cycle spacing; led_pattern tracks the sequence. Dropping run_en gives DONE after any in-flight write completes.
- Slave with random AWREADY/WREADY/ARREADY/B/R delays (0-5 cycles), AW accepted before W and vice versa: VALID signals and payload stay stable until handshake; results identical to the zero-wait case.
- start pulsed while busy: ignored. ARESETN asserted during RD_DATA: all outputs at reset values immediately; the next start runs a clean init.

Source files
------------

// File: rtl/toggle_leds_cfg_seq.sv
// ---------------------------------------------------------------------------
// toggle_leds_cfg_seq
//
// AXI4-Lite master that configures the toggle_leds peripheral without a CPU.
// A start pulse writes registers 0x0..0xC with the values 1..4. It then reads
// each one back and checks it. If run_en is high after a clean init, the
// block enters a run loop. Every C_TICK_CYCLES clocks it rotates led_pattern
// left by one and writes the new pattern to register 0x0.
//
// Ports
//   ACLK, ARESETN       clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse; starts init from IDLE/DONE/ERR
//   run_en              level; keeps the run loop alive after init
//   busy                high in every state except IDLE/DONE/ERR
//   done, error         sticky status flags, both cleared by an accepted start
//   led_pattern         last pattern that reg0 acknowledged in run mode
//   M_AXI_*             AXI4-Lite master port (AW/W/B/AR/R channels)
// ---------------------------------------------------------------------------
module toggle_leds_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_LED_WIDTH        = 4,
  parameter int C_TICK_CYCLES      = 100000000
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic                          run_en,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [C_LED_WIDTH-1:0]        led_pattern,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int LW    = C_LED_WIDTH;
  localparam int CNT_W = $clog2(C_TICK_CYCLES);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(C_TICK_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA,
    RUN_WAIT, RUN_WR, RUN_RESP, DONE, ERR
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic            issued_reg, issued_next;   // VALIDs already raised in this state
  logic            aw_done_reg, aw_done_next;
  logic            w_done_reg, w_done_next;
  logic            awvalid_reg, awvalid_next;
  logic            wvalid_reg, wvalid_next;
  logic            bready_reg, bready_next;
  logic            arvalid_reg, arvalid_next;
  logic            rready_reg, rready_next;
  logic [AW-1:0]   awaddr_reg, awaddr_next;
  logic [AW-1:0]   araddr_reg, araddr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [3:0]      wstrb_reg, wstrb_next;
  logic            done_reg, done_next;
  logic            error_reg, error_next;
  logic [LW-1:0]   led_reg, led_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Handshake qualifiers, shared by the next-state and output processes
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_accepted, b_ok, rd_ok, tick_end, idle_like;
  logic [AW-1:0] idx_addr;
  logic [DW-1:0] idx_data;
  logic [LW-1:0] led_rot;

  assign aw_hs = awvalid_reg & M_AXI_AWREADY;
  assign w_hs  = wvalid_reg  & M_AXI_WREADY;
  assign b_hs  = bready_reg  & M_AXI_BVALID;
  assign ar_hs = arvalid_reg & M_AXI_ARREADY;
  assign r_hs  = rready_reg  & M_AXI_RVALID;

  // AW and W may be accepted in either order or in the same cycle
  assign wr_accepted = issued_reg & (aw_done_reg | aw_hs) & (w_done_reg | w_hs);

  assign idx_addr = AW'({idx_reg, 2'b00});
  assign idx_data = DW'(idx_reg) + DW'(1);
  assign b_ok     = (M_AXI_BRESP == 2'b00);
  assign rd_ok    = (M_AXI_RRESP == 2'b00) && (M_AXI_RDATA == idx_data);
  assign tick_end = (cnt_reg == TICK_LAST);
  assign led_rot  = {led_reg[LW-2:0], led_reg[LW-1]};
  assign idle_like = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);

  // State and datapath registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      issued_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awaddr_reg  <= '0;
      araddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      led_reg     <= LW'(1);
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      issued_reg  <= issued_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awaddr_reg  <= awaddr_next;
      araddr_reg  <= araddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      led_reg     <= led_next;
      cnt_reg     <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ERR: if (start) state_next = WR_ADDR_DATA;
      DONE: begin
        if (start)       state_next = WR_ADDR_DATA;
        else if (run_en) state_next = RUN_WAIT;
      end
      WR_ADDR_DATA: if (wr_accepted) state_next = WR_RESP;
      WR_RESP: begin
        if (b_hs) begin
          if (!b_ok)              state_next = ERR;
          else if (idx_reg == 2'd3) state_next = RD_ADDR;
          else                    state_next = WR_ADDR_DATA;
        end
      end
      RD_ADDR: if (ar_hs) state_next = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          if (!rd_ok)               state_next = ERR;
          else if (idx_reg != 2'd3) state_next = RD_ADDR;
          else if (run_en)          state_next = RUN_WAIT;
          else                      state_next = DONE;
        end
      end
      // Leaving the loop takes priority over a coincident tick
      RUN_WAIT: begin
        if (!run_en)       state_next = DONE;
        else if (tick_end) state_next = RUN_WR;
      end
      RUN_WR: if (wr_accepted) state_next = RUN_RESP;
      RUN_RESP: if (b_hs) state_next = b_ok ? RUN_WAIT : ERR;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_next     = idx_reg;
    issued_next  = issued_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    awaddr_next  = awaddr_reg;
    araddr_next  = araddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    done_next    = done_reg;
    error_next   = error_reg;
    led_next     = led_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        // Hold the tick counter at zero so every entry to RUN_WAIT starts a full period
        cnt_next = '0;
        if (start) begin
          done_next   = 1'b0;
          error_next  = 1'b0;
          idx_next    = '0;
          issued_next = 1'b0;
        end
      end
      WR_ADDR_DATA, RUN_WR: begin
        if (!issued_reg) begin
          issued_next  = 1'b1;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          wstrb_next   = 4'hF;
          if (state_reg == RUN_WR) begin
            awaddr_next = '0;
            wdata_next  = DW'(led_rot);
          end else begin
            awaddr_next = idx_addr;
            wdata_next  = idx_data;
          end
        end else begin
          if (aw_hs) begin
            awvalid_next = 1'b0;
            aw_done_next = 1'b1;
          end
          if (w_hs) begin
            wvalid_next = 1'b0;
            w_done_next = 1'b1;
          end
          if (wr_accepted) begin
            bready_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            issued_next  = 1'b0;
          end
        end
      end
      WR_RESP, RUN_RESP: begin
        if (b_hs) begin
          bready_next = 1'b0;
          if (!b_ok)                  error_next = 1'b1;
          else if (state_reg == WR_RESP) idx_next = idx_reg + 2'd1;
          else                        led_next = wdata_reg[LW-1:0];
        end
      end
      RD_ADDR: begin
        if (!issued_reg) begin
          issued_next  = 1'b1;
          arvalid_next = 1'b1;
          araddr_next  = idx_addr;
        end else if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          issued_next  = 1'b0;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_next = 1'b0;
          if (!rd_ok) begin
            error_next = 1'b1;
          end else begin
            idx_next = idx_reg + 2'd1;
            if (idx_reg == 2'd3) done_next = 1'b1;
          end
        end
      end
      RUN_WAIT: cnt_next = tick_end ? '0 : cnt_reg + CNT_W'(1);
      default: ;
    endcase
  end

  assign busy          = !idle_like;
  assign done          = done_reg;
  assign error         = error_reg;
  assign led_pattern   = led_reg;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_toggle_leds_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_toggle_leds_cfg_seq
//
// Directed bench for toggle_leds_cfg_seq with C_TICK_CYCLES = 8. An in-bench
// AXI4-Lite slave models the four toggle_leds registers. It can inject faults:
// RDATA=0xDEAD at 0x8, or SLVERR on the 0x4 write. It can add random
// READY/response delays or stall the R channel. The slave prints one line
// per transaction and counts any VALID/payload change before a handshake.
// ---------------------------------------------------------------------------
module tb_toggle_leds_cfg_seq;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          start = 1'b0;
  logic          run_en = 1'b0;
  logic          busy, done, error;
  logic [LW-1:0] led_pattern;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  toggle_leds_cfg_seq #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .C_LED_WIDTH(LW), .C_TICK_CYCLES(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .run_en(run_en),
    .busy(busy), .done(done), .error(error), .led_pattern(led_pattern),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  int cyc = 0;
  initial forever begin
    @(posedge ACLK);
    cyc = cyc + 1;
  end

  // Slave configuration (written by the tests only)
  bit rand_mode = 1'b0;
  bit fault_rd8 = 1'b0;
  bit fault_b4  = 1'b0;
  int r_extra   = 0;

  // Slave observations (written by the slave only)
  int            rd_count = 0;
  int            stab_viol = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];

  // Slave: sample on the falling edge (what the DUT will see at the next
  // rising edge), then update outputs 1 time unit after the rising edge.
  initial begin : slave
    logic [DW-1:0] regs [4];
    bit aw_f, w_f, b_f, ar_f, r_f;
    bit got_aw, got_w, b_pend, r_pend;
    int b_cnt, r_cnt;
    logic [AW-1:0] aw_l, ar_l;
    logic [DW-1:0] w_l, r_l;
    logic [1:0]    b_l;
    bit p_awv, p_wv, p_arv;
    logic [AW-1:0] p_awa, p_ara;
    logic [DW-1:0] p_wd;
    logic [3:0]    p_ws;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; b_cnt = 0; r_cnt = 0;
    p_awv = 0; p_wv = 0; p_arv = 0;
    aw_l = '0; ar_l = '0; w_l = '0; r_l = '0; b_l = '0;
    p_awa = '0; p_ara = '0; p_wd = '0; p_ws = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    forever begin
      @(negedge ACLK);
      aw_f = M_AXI_AWVALID && M_AXI_AWREADY;
      w_f  = M_AXI_WVALID  && M_AXI_WREADY;
      b_f  = M_AXI_BVALID  && M_AXI_BREADY;
      ar_f = M_AXI_ARVALID && M_AXI_ARREADY;
      r_f  = M_AXI_RVALID  && M_AXI_RREADY;
      if (aw_f) aw_l = M_AXI_AWADDR;
      if (w_f)  w_l  = M_AXI_WDATA;
      if (ar_f) ar_l = M_AXI_ARADDR;
      if (ARESETN) begin
        if (p_awv && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awa)) stab_viol++;
        if (p_wv && (!M_AXI_WVALID || M_AXI_WDATA !== p_wd || M_AXI_WSTRB !== p_ws)) stab_viol++;
        if (p_arv && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_ara)) stab_viol++;
        p_awv = M_AXI_AWVALID && !aw_f; p_awa = M_AXI_AWADDR;
        p_wv  = M_AXI_WVALID && !w_f;   p_wd = M_AXI_WDATA; p_ws = M_AXI_WSTRB;
        p_arv = M_AXI_ARVALID && !ar_f; p_ara = M_AXI_ARADDR;
      end else begin
        p_awv = 0; p_wv = 0; p_arv = 0;
      end
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        for (int i = 0; i < 4; i++) regs[i] = '0;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
        continue;
      end
      if (aw_f) got_aw = 1;
      if (w_f)  got_w  = 1;
      if (b_f)  M_AXI_BVALID = 1'b0;
      if (r_f)  M_AXI_RVALID = 1'b0;
      if (got_aw && got_w) begin
        b_l = (fault_b4 && aw_l == AW'(4)) ? 2'b10 : 2'b00;
        if (b_l == 2'b00) regs[aw_l[3:2]] = w_l;
        wr_addr_q.push_back(aw_l);
        wr_data_q.push_back(w_l);
        wr_cyc_q.push_back(cyc);
        $display("[%0d] AXI write addr=0x%0h data=0x%0h bresp=%0d", cyc, aw_l, w_l, b_l);
        b_cnt = rand_mode ? int'($urandom_range(0, 5)) : 0;
        b_pend = 1; got_aw = 0; got_w = 0;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin
          M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_l; b_pend = 0;
        end else b_cnt--;
      end
      if (ar_f) begin
        rd_count++;
        r_l = (fault_rd8 && ar_l == AW'(8)) ? 32'h0000_DEAD : regs[ar_l[3:2]];
        $display("[%0d] AXI read  addr=0x%0h data=0x%0h", cyc, ar_l, r_l);
        r_cnt = (rand_mode ? int'($urandom_range(0, 5)) : 0) + r_extra;
        r_pend = 1;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          M_AXI_RVALID = 1'b1; M_AXI_RDATA = r_l; M_AXI_RRESP = 2'b00; r_pend = 0;
        end else r_cnt--;
      end
      M_AXI_AWREADY = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      M_AXI_WREADY  = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      M_AXI_ARREADY = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic apply_reset();
    ARESETN = 1'b0; start = 1'b0; run_en = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  // Returns at the falling edge right after the rising edge that samples start
  task automatic pulse_start();
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL reset_valids got=%b exp=00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    n_checks++;
    if (M_AXI_AWADDR !== 4'h0 || M_AXI_ARADDR !== 4'h0 || M_AXI_WDATA !== 32'h0 || M_AXI_WSTRB !== 4'h0) begin
      n_fail++; $display("FAIL reset_payload awaddr=%h araddr=%h wdata=%h wstrb=%h exp all 0",
        M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB);
    end
    n_checks++;
    if ({busy, done, error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status busy/done/error got=%b exp=000", {busy, done, error});
    end
    n_checks++;
    if (led_pattern !== 4'h1) begin
      n_fail++; $display("FAIL reset_led got=%h exp=1", led_pattern);
    end
  endtask

  task automatic test_init_zero_wait();
    int wb, rb;
    wb = wr_addr_q.size(); rb = rd_count;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL init_busy_after_start got=%b exp=1", busy); end
    repeat (23) @(negedge ACLK);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL init_cycle23 done=%b busy=%b exp done=0 busy=1", done, busy);
    end
    @(negedge ACLK);
    n_checks++;
    if ({done, error, busy} !== 3'b100) begin
      n_fail++; $display("FAIL init_cycle24 done/error/busy got=%b exp=100", {done, error, busy});
    end
    n_checks++;
    if (wr_addr_q.size() - wb != 4 || rd_count - rb != 4) begin
      n_fail++; $display("FAIL init_txn_count writes=%0d reads=%0d exp 4/4", wr_addr_q.size() - wb, rd_count - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wr_addr_q[wb+i] !== AW'(i*4) || wr_data_q[wb+i] !== DW'(i+1)) begin
          n_fail++; $display("FAIL init_write%0d got addr=%h data=%h exp addr=%h data=%h",
            i, wr_addr_q[wb+i], wr_data_q[wb+i], i*4, i+1);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int wb;
    wb = wr_addr_q.size();
    pulse_start();
    for (int c = 1; c <= 24; c++) begin
      start = (c == 5);
      @(negedge ACLK);
    end
    start = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b10 || wr_addr_q.size() - wb != 4) begin
      n_fail++; $display("FAIL start_ignored_busy done=%b busy=%b writes=%0d exp done=1 busy=0 writes=4",
        done, busy, wr_addr_q.size() - wb);
    end
  endtask

  task automatic test_readback_error();
    int wb, rb;
    bit ok;
    fault_rd8 = 1'b1;
    wb = wr_addr_q.size(); rb = rd_count;
    pulse_start();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rderr_start_clears_done got=%b exp=0", done); end
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rderr_timeout busy=%b exp=0", busy); end
    n_checks++;
    if ({error, done} !== 2'b10) begin
      n_fail++; $display("FAIL rderr_status error/done got=%b exp=10", {error, done});
    end
    repeat (20) @(negedge ACLK);
    n_checks++;
    if (wr_addr_q.size() - wb != 4 || rd_count - rb != 3) begin
      n_fail++; $display("FAIL rderr_traffic writes=%0d reads=%0d exp 4/3", wr_addr_q.size() - wb, rd_count - rb);
    end
    fault_rd8 = 1'b0;
    pulse_start();
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL rderr_start_clears_error got=%b exp=0", error); end
    wait_idle(100, ok);
    n_checks++;
    if (!ok || {done, error} !== 2'b10) begin
      n_fail++; $display("FAIL rderr_rerun ok=%0d done/error got=%b exp=10", ok, {done, error});
    end
  endtask

  task automatic test_bresp_error();
    int wb, rb;
    bit ok;
    fault_b4 = 1'b1;
    wb = wr_addr_q.size(); rb = rd_count;
    pulse_start();
    wait_idle(100, ok);
    n_checks++;
    if (!ok || {error, done} !== 2'b10) begin
      n_fail++; $display("FAIL bresp_status ok=%0d error/done got=%b exp=10", ok, {error, done});
    end
    n_checks++;
    if (wr_addr_q.size() - wb != 2 || rd_count - rb != 0) begin
      n_fail++; $display("FAIL bresp_traffic writes=%0d reads=%0d exp 2/0", wr_addr_q.size() - wb, rd_count - rb);
    end
    fault_b4 = 1'b0;
  endtask

  task automatic test_run_loop();
    logic [LW-1:0] exp_led [5];
    logic [LW-1:0] prev;
    int wb;
    bit ok;
    exp_led[0] = 4'h2; exp_led[1] = 4'h4; exp_led[2] = 4'h8; exp_led[3] = 4'h1; exp_led[4] = 4'h2;
    apply_reset();
    run_en = 1'b1;
    wb = wr_addr_q.size();
    pulse_start();
    prev = 4'h1;
    for (int k = 0; k < 5; k++) begin
      ok = 0;
      for (int i = 0; i < 80; i++) begin
        if (wr_addr_q.size() >= wb + 5 + k) begin ok = 1; break; end
        @(negedge ACLK);
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL run_write%0d_timeout", k); break; end
      // AW/W accepted on the last edge; B completes on the next one
      n_checks++;
      if (led_pattern !== prev) begin
        n_fail++; $display("FAIL run_led_early%0d got=%h exp=%h", k, led_pattern, prev);
      end
      @(negedge ACLK);
      n_checks++;
      if (led_pattern !== exp_led[k]) begin
        n_fail++; $display("FAIL run_led%0d got=%h exp=%h", k, led_pattern, exp_led[k]);
      end
      n_checks++;
      if (wr_addr_q[wb+4+k] !== 4'h0 || wr_data_q[wb+4+k] !== DW'(exp_led[k])) begin
        n_fail++; $display("FAIL run_data%0d got addr=%h data=%h exp addr=0 data=%h",
          k, wr_addr_q[wb+4+k], wr_data_q[wb+4+k], exp_led[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (wr_cyc_q[wb+4+k] - wr_cyc_q[wb+3+k] != 11) begin
          n_fail++; $display("FAIL run_period%0d got=%0d exp=11", k, wr_cyc_q[wb+4+k] - wr_cyc_q[wb+3+k]);
        end
      end
      prev = exp_led[k];
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy got=%b exp=1", busy); end
    // Now in RUN_WAIT: dropping run_en gives DONE on the next edge
    run_en = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_fail++; $display("FAIL run_stop busy/done got=%b exp=01", {busy, done});
    end
    // Resume, then drop run_en while a write is in flight
    run_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) begin ok = 1; break; end
    end
    run_en = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL run_resume_timeout awvalid=%b exp=1", M_AXI_AWVALID); end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || wr_addr_q.size() - wb != 10 || led_pattern !== 4'h4 || done !== 1'b1) begin
      n_fail++; $display("FAIL run_inflight ok=%0d writes=%0d led=%h done=%b exp writes=10 led=4 done=1",
        ok, wr_addr_q.size() - wb, led_pattern, done);
    end
  endtask

  task automatic test_random_delays();
    int wb, rb, sb;
    bit ok;
    apply_reset();
    rand_mode = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      wb = wr_addr_q.size(); rb = rd_count; sb = stab_viol;
      pulse_start();
      wait_idle(400, ok);
      n_checks++;
      if (!ok || {done, error} !== 2'b10) begin
        n_fail++; $display("FAIL rand%0d_status ok=%0d done/error got=%b exp=10", pass, ok, {done, error});
      end
      n_checks++;
      if (wr_addr_q.size() - wb != 4 || rd_count - rb != 4) begin
        n_fail++; $display("FAIL rand%0d_traffic writes=%0d reads=%0d exp 4/4", pass, wr_addr_q.size() - wb, rd_count - rb);
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (wr_addr_q[wb+i] !== AW'(i*4) || wr_data_q[wb+i] !== DW'(i+1)) begin
            n_fail++; $display("FAIL rand%0d_write%0d got addr=%h data=%h exp addr=%h data=%h",
              pass, i, wr_addr_q[wb+i], wr_data_q[wb+i], i*4, i+1);
          end
        end
      end
      n_checks++;
      if (stab_viol != sb) begin
        n_fail++; $display("FAIL rand%0d_stability violations=%0d exp=0", pass, stab_viol - sb);
      end
    end
    rand_mode = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid_read();
    int wb;
    bit ok;
    apply_reset();
    r_extra = 30;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (M_AXI_RREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrd_wait_rready got=%b exp=1", M_AXI_RREADY); end
    ARESETN = 1'b0;
    #1;
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, error} !== 8'b0
        || M_AXI_ARADDR !== 4'h0 || M_AXI_AWADDR !== 4'h0 || M_AXI_WDATA !== 32'h0 || led_pattern !== 4'h1) begin
      n_fail++; $display("FAIL midrd_async_reset flags=%b araddr=%h awaddr=%h wdata=%h led=%h exp all 0, led=1",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, busy, done, error},
        M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, led_pattern);
    end
    r_extra = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    wb = wr_addr_q.size();
    pulse_start();
    wait_idle(100, ok);
    n_checks++;
    if (!ok || {done, error} !== 2'b10 || wr_addr_q.size() - wb != 4) begin
      n_fail++; $display("FAIL midrd_clean_init ok=%0d done/error=%b writes=%0d exp done=1 error=0 writes=4",
        ok, {done, error}, wr_addr_q.size() - wb);
    end
  endtask

  initial begin
    test_reset();
    test_init_zero_wait();
    test_start_while_busy();
    test_readback_error();
    test_bresp_error();
    test_run_loop();
    test_random_delays();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
